idct_transpose_pingpong: RTL and testbench

//  - Double-buffered N x N transpose memory between the row and column 1-D IDCT passes.
//  - Accepts one block row-major on a valid/ready input stream and emits it column-major on a

---
 rtl/idct_pkg.sv | 10 +
 rtl/idct_bank_ram.sv | 24 ++
 rtl/idct_transpose_pingpong.sv | 76 +++++++
 tb/tb_idct_transpose_pingpong.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// idct_pkg: shared defaults and the transposed-index helper for the IDCT transpose buffer
package idct_pkg;
    localparam int WIDTH_X_DEF = 16;
    localparam int N_DEF = 8;
    function automatic int tr_addr(input int cnt, input int log2n);
        int mask;
        mask = (1 << log2n) - 1;
        return ((cnt & mask) << log2n) | ((cnt >> log2n) & mask);
    endfunction
endpackage

// File: rtl/idct_bank_ram.sv
// idct_bank_ram: simple dual-port RAM holding both banks; bank bit is the address MSB
module idct_bank_ram
    import idct_pkg::*;
#(
    parameter int WIDTH = WIDTH_X_DEF,
    parameter int AW = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge clk)
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/idct_transpose_pingpong.sv
// idct_transpose_pingpong: double-buffered NxN transpose between row and column IDCT passes
// Define TBUF_LINEAR_MODE_EN to add a `linear` input that selects row-major readout per block.
module idct_transpose_pingpong
    import idct_pkg::*;
#(
    parameter int WIDTH_X = WIDTH_X_DEF,
    parameter int N = N_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef TBUF_LINEAR_MODE_EN
    input  logic               linear,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_X-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_X-1:0] out_data,
    output logic               out_last
);
    localparam int LOG2N = $clog2(N);
    localparam int ADDR_W = 2 * LOG2N;
    localparam logic [ADDR_W-1:0] LAST = '1;
    logic wr_bank, rd_bank, wr_en, rd_en, wr_done, rd_done;
    logic [1:0] full;
    logic [ADDR_W-1:0] wr_cnt, rd_cnt, rd_idx;
    assign in_ready = !full[wr_bank];
    assign wr_en = in_valid & in_ready;
    assign rd_en = full[rd_bank] & (!out_valid | out_ready);
    assign wr_done = wr_en & (wr_cnt == LAST);
    assign rd_done = rd_en & (rd_cnt == LAST);
`ifdef TBUF_LINEAR_MODE_EN
    logic lin_q, lin;
    // The mode seen at a block's first read is held for the rest of that block.
    assign lin = (rd_cnt == '0) ? linear : lin_q;
    always_ff @(posedge clk)
        if (!rst_n) lin_q <= 1'b0;
        else if (rd_en && rd_cnt == '0) lin_q <= linear;
    assign rd_idx = lin ? rd_cnt : ADDR_W'(tr_addr(int'(rd_cnt), LOG2N));
`else
    assign rd_idx = ADDR_W'(tr_addr(int'(rd_cnt), LOG2N));
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            full      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (wr_en) wr_cnt <= wr_cnt + 1'b1;
            if (rd_en) begin
                rd_cnt   <= rd_cnt + 1'b1;
                out_last <= rd_done;
            end
            wr_bank   <= wr_bank ^ wr_done;
            rd_bank   <= rd_bank ^ rd_done;
            // Set and clear always target different banks, so both apply together.
            full      <= (full | (2'(wr_done) << wr_bank)) & ~(2'(rd_done) << rd_bank);
            out_valid <= rd_en | (out_valid & !out_ready);
        end
    end
    idct_bank_ram #(.WIDTH(WIDTH_X), .AW(ADDR_W + 1)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr ({wr_bank, wr_cnt}),
        .wdata (in_data),
        .re    (rd_en),
        .raddr ({rd_bank, rd_idx}),
        .rdata (out_data)
    );
endmodule

// File: tb/tb_idct_transpose_pingpong.sv
// tb_idct_transpose_pingpong: scoreboard bench for the ping-pong transpose buffer
module tb_idct_transpose_pingpong;
    localparam int N = 8;
    localparam int W = 16;
    logic clk = 0;
    logic rst_n = 0;
    logic in_valid = 0;
    logic out_ready = 1;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid, out_last;
    logic [W-1:0] out_data;
`ifdef TBUF_LINEAR_MODE_EN
    logic linear = 0;
`endif
    int vectors = 0;
    int miscompares = 0;
    int stall_cycles = 0;
    logic [W:0] exp_q[$];
    logic [W:0] e_m;
    logic stall_prev = 0;
    logic [W-1:0] prev_d;
    logic prev_l;

    idct_transpose_pingpong #(.WIDTH_X(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef TBUF_LINEAR_MODE_EN
        .linear    (linear),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) stall_prev = 0;
        else begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", 32'(out_data), 32'(prev_d));
                check("stall_last", 32'(out_last), 32'(prev_l));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got %0h expected no output", out_data);
                end else begin
                    e_m = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e_m[W-1:0]));
                    check("out_last", 32'(out_last), 32'(e_m[W]));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
        end
    end

    task automatic push_block(input int base, input bit lin);
        for (int k = 0; k < N * N; k++) begin
            int idx;
            idx = lin ? k : (k % N) * N + k / N;
            exp_q.push_back({(k == N * N - 1), W'(base + idx)});
        end
    endtask

    task automatic send_word(input logic [W-1:0] v);
        int n;
        n = 0;
        in_valid = 1;
        in_data = v;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        stall_cycles += n;
        if (n >= 1000) begin
            vectors++;
            miscompares++;
            $display("FAIL in_accept_timeout: got in_ready=0 expected 1 within 1000 cycles");
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send_block(input int base, input bit lin);
        push_block(base, lin);
        for (int i = 0; i < N * N; i++) send_word(W'(base + i));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic watch_gaps();
        int n, gaps;
        n = 0;
        gaps = 0;
        while (!out_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 2 * N * N; i++) begin
            if (!out_valid) gaps++;
            @(posedge clk); #1;
        end
        check("t2_out_gaps", 32'(gaps), 0);
    endtask

    task automatic watch_bp();
        int n;
        n = 0;
        while (!(out_valid && out_data == 16) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_found16", 32'(out_data), 16);
        out_ready = 0;
        repeat (5) begin
            @(posedge clk); #1;
            check("t4_hold_valid", 32'(out_valid), 1);
            check("t4_hold_data", 32'(out_data), 16);
        end
        out_ready = 1;
        @(posedge clk); #1;
        check("t4_next_data", 32'(out_data), 24);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Single block, transposed, with latency check
        send_block(0, 0);
        check("t1_valid_edge_t", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("t1_valid_edge_t1", 32'(out_valid), 1);
        check("t1_first_data", 32'(out_data), 0);
        drain();

        // Back-to-back blocks with no input stalls or output gaps
        stall_cycles = 0;
        fork
            begin send_block(0, 0); send_block(100, 0); end
            watch_gaps();
        join
        check("t2_in_stalls", 32'(stall_cycles), 0);
        drain();

        // Both banks fill while the consumer is stalled
        out_ready = 0;
        send_block(1000, 0);
        send_block(16'hFFC0, 0);
        check("t3_in_ready_full", 32'(in_ready), 0);
        check("t3_word0_held", 32'(out_data), 1000);
        out_ready = 1;
        for (int i = 1; i < N * N; i++) begin
            @(posedge clk); #1;
            check("t3_in_ready", 32'(in_ready), 32'(i == N * N - 1));
        end
        drain();

        // Backpressure while out_data is 16
        fork
            send_block(0, 0);
            watch_bp();
        join
        drain();

        // Reset mid-block discards the partial block
        for (int i = 0; i < 30; i++) send_word(W'(500 + i));
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("t5_in_ready", 32'(in_ready), 1);
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_out_data", 32'(out_data), 0);
        send_block(0, 0);
        drain();

`ifdef TBUF_LINEAR_MODE_EN
        // Linear readout, with a mid-block toggle only affecting the next block
        linear = 1;
        send_block(300, 1);
        repeat (10) @(posedge clk);
        #1 linear = 0;
        send_block(400, 0);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
